// File: rtl/psum_wb_ctrl.sv
// Partial-sum writeback sequencer: walks column banks (inner loop) and SRAM addresses
// (outer loop), driving a one-hot bank enable, read address and writeback-valid strobe.
module psum_wb_ctrl #(
    parameter int PE_COL    = 32,
    parameter int ADDR_W    = 8,
    parameter int COL_W     = 6,
    parameter int DRAIN_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_Start,
    input  logic [COL_W-1:0]  i_Num_Cols,
    input  logic [ADDR_W:0]   i_Num_Addr,
    input  logic [ADDR_W-1:0] i_Base_Addr,
    input  logic              i_Stall,
    output logic [PE_COL-1:0] o_Psram_En,
    output logic [ADDR_W-1:0] o_Psram_Addr,
    output logic              o_Valid_WB_Psum,
    output logic              o_Busy,
    output logic              o_Done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [COL_W-1:0] PE_COL_C = COL_W'(PE_COL);
    localparam int DRAIN_W = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LAT - 1);

    state_t              state_q, state_d;
    logic [COL_W-1:0]    cols_q, cols_d, col_q, col_d;
    logic [ADDR_W:0]     num_q, num_d, aoff_q, aoff_d;
    logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [PE_COL-1:0]   en_q, en_d;
    logic                valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    // Read about to be issued: taken straight from the start inputs while idle,
    // from the latched configuration and counters otherwise.
    logic                in_idle;
    logic [COL_W-1:0]    eff_cols, cur_cols, cur_col;
    logic [ADDR_W:0]     cur_num, cur_aoff;
    logic [ADDR_W-1:0]   cur_base;
    logic [PE_COL-1:0]   onehot;
    logic                last_read, last_col, issue_now;

    assign in_idle   = (state_q == IDLE);
    assign eff_cols  = (i_Num_Cols > PE_COL_C) ? PE_COL_C : i_Num_Cols;
    assign cur_cols  = in_idle ? eff_cols    : cols_q;
    assign cur_num   = in_idle ? i_Num_Addr  : num_q;
    assign cur_base  = in_idle ? i_Base_Addr : base_q;
    assign cur_col   = in_idle ? '0          : col_q;
    assign cur_aoff  = in_idle ? '0          : aoff_q;
    assign last_col  = (cur_col == cur_cols - 1'b1);
    assign last_read = last_col && (cur_aoff == cur_num - 1'b1);

    for (genvar gi = 0; gi < PE_COL; gi++) begin : g_onehot
        assign onehot[gi] = (cur_col == COL_W'(gi));
    end

    always_comb begin
        state_d   = state_q;
        cols_d    = cols_q;
        num_d     = num_q;
        base_d    = base_q;
        col_d     = col_q;
        aoff_d    = aoff_q;
        drain_d   = drain_q;
        en_d      = '0;
        addr_d    = addr_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        issue_now = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (i_Start) begin
                    cols_d = eff_cols;
                    num_d  = i_Num_Addr;
                    base_d = i_Base_Addr;
                    busy_d = 1'b1;
                    if (eff_cols == '0 || i_Num_Addr == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        issue_now = 1'b1;
                    end
                end
            end
            ISSUE: issue_now = !i_Stall;
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (issue_now) begin
            en_d    = onehot;
            addr_d  = cur_base + cur_aoff[ADDR_W-1:0];
            valid_d = 1'b1;
            if (last_read) begin
                state_d = DRAIN;
                drain_d = '0;
                col_d   = '0;
                aoff_d  = '0;
            end else begin
                state_d = ISSUE;
                col_d   = last_col ? '0 : cur_col + 1'b1;
                aoff_d  = last_col ? cur_aoff + 1'b1 : cur_aoff;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cols_q  <= '0;
            num_q   <= '0;
            base_q  <= '0;
            col_q   <= '0;
            aoff_q  <= '0;
            drain_q <= '0;
            en_q    <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cols_q  <= cols_d;
            num_q   <= num_d;
            base_q  <= base_d;
            col_q   <= col_d;
            aoff_q  <= aoff_d;
            drain_q <= drain_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_Psram_En      = en_q;
    assign o_Psram_Addr    = addr_q;
    assign o_Valid_WB_Psum = valid_q;
    assign o_Busy          = busy_q;
    assign o_Done          = done_q;

    // The writeback stage OR-reduces the banks, so at most one may be enabled.
    a_en_onehot0: assert property (@(posedge CLK) disable iff (RST) $onehot0(o_Psram_En));

endmodule

// File: tb/tb_psum_wb_ctrl.sv
// Self-checking bench for psum_wb_ctrl: table of run configurations checked through a
// read scoreboard, plus a hand-written abort sequence (reset mid-issue, start while busy).
module tb_psum_wb_ctrl;
    localparam int PE_COL = 32;
    localparam int ADDR_W = 8;
    localparam int COL_W  = 6;

    logic              CLK = 1'b0;
    logic              RST;
    logic              i_Start;
    logic [COL_W-1:0]  i_Num_Cols;
    logic [ADDR_W:0]   i_Num_Addr;
    logic [ADDR_W-1:0] i_Base_Addr;
    logic              i_Stall;
    logic [PE_COL-1:0] o_Psram_En;
    logic [ADDR_W-1:0] o_Psram_Addr;
    logic              o_Valid_WB_Psum;
    logic              o_Busy;
    logic              o_Done;

    psum_wb_ctrl #(.PE_COL(PE_COL), .ADDR_W(ADDR_W), .COL_W(COL_W), .DRAIN_LAT(2)) dut (
        .CLK(CLK), .RST(RST), .i_Start(i_Start), .i_Num_Cols(i_Num_Cols),
        .i_Num_Addr(i_Num_Addr), .i_Base_Addr(i_Base_Addr), .i_Stall(i_Stall),
        .o_Psram_En(o_Psram_En), .o_Psram_Addr(o_Psram_Addr),
        .o_Valid_WB_Psum(o_Valid_WB_Psum), .o_Busy(o_Busy), .o_Done(o_Done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cols; int num; int base; int stall_at; int stall_len; int exp_reads; int exp_span;
    } vec_t;
    typedef struct {
        logic [PE_COL-1:0] en;
        logic [ADDR_W-1:0] addr;
    } rd_t;

    rd_t  sb_q[$];
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_expected(input int cols, input int num, input int base);
        int eff;
        rd_t r;
        eff = (cols > PE_COL) ? PE_COL : cols;
        for (int a = 0; a < num; a++) begin
            for (int c = 0; c < eff; c++) begin
                r.en    = '0;
                r.en[c] = 1'b1;
                r.addr  = ADDR_W'(base + a);
                sb_q.push_back(r);
            end
        end
    endtask

    task automatic observe(input string tag, output bit issued);
        rd_t e;
        issued = (o_Psram_En != '0);
        check({tag, "/valid"}, 64'(o_Valid_WB_Psum), 64'(issued));
        check({tag, "/onehot"}, 64'($countones(o_Psram_En) <= 1), 64'd1);
        if (issued) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL %s/extra_read: got en=%0h addr=%0h want none", tag, o_Psram_En, o_Psram_Addr);
            end else begin
                e = sb_q.pop_front();
                check({tag, "/en"}, 64'(o_Psram_En), 64'(e.en));
                check({tag, "/addr"}, 64'(o_Psram_Addr), 64'(e.addr));
            end
        end
    endtask

    task automatic drive_start(input int cols, input int num, input int base);
        i_Start     = 1'b1;
        i_Num_Cols  = COL_W'(cols);
        i_Num_Addr  = (ADDR_W+1)'(num);
        i_Base_Addr = ADDR_W'(base);
    endtask

    task automatic run_case(input vec_t v, input int idx);
        string tag;
        bit    issued;
        bit    done_seen;
        int    cyc, n_reads, first, last, done_cyc, stall_left;
        tag = $sformatf("vec%0d", idx);
        done_seen = 0; n_reads = 0; first = 0; last = 0; done_cyc = 0; stall_left = 0;
        push_expected(v.cols, v.num, v.base);
        @(posedge CLK); #1;
        drive_start(v.cols, v.num, v.base);
        @(posedge CLK); #1;
        i_Start = 1'b0;
        cyc = 1;
        while (!done_seen && cyc <= 2000) begin
            observe(tag, issued);
            if (issued) begin
                n_reads++;
                if (first == 0) first = cyc;
                last = cyc;
                if (v.stall_len > 0 && n_reads == v.stall_at) stall_left = v.stall_len;
            end
            check({tag, "/busy"}, 64'(o_Busy), 64'd1);
            if (o_Done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            i_Stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            if (!done_seen) begin
                @(posedge CLK); #1;
                cyc++;
            end
        end
        i_Stall = 1'b0;
        check({tag, "/done_seen"}, 64'(done_seen), 64'd1);
        check({tag, "/reads"}, 64'(n_reads), 64'(v.exp_reads));
        check({tag, "/sb_left"}, 64'(sb_q.size()), 64'd0);
        if (v.exp_reads > 0) begin
            check({tag, "/first"}, 64'(first), 64'd1);
            check({tag, "/span"}, 64'(last - first + 1), 64'(v.exp_span));
            check({tag, "/done_cyc"}, 64'(done_cyc), 64'(last + 2));
        end else begin
            check({tag, "/done_cyc"}, 64'(done_cyc), 64'd1);
        end
        @(posedge CLK); #1;
        check({tag, "/busy_after"}, 64'(o_Busy), 64'd0);
        check({tag, "/done_after"}, 64'(o_Done), 64'd0);
        $display("%s: cols=%0d num=%0d base=%0h stall=%0d@%0d reads=%0d done_cyc=%0d",
                 tag, v.cols, v.num, v.base, v.stall_len, v.stall_at, n_reads, done_cyc);
        sb_q.delete();
    endtask

    task automatic run_abort();
        bit issued;
        bit pulsed;
        int n_reads;
        pulsed = 0; n_reads = 0;
        push_expected(4, 2, 8'h10);
        @(posedge CLK); #1;
        drive_start(4, 2, 8'h10);
        @(posedge CLK); #1;
        i_Start = 1'b0;
        for (int cyc = 1; cyc <= 20 && n_reads < 5; cyc++) begin
            observe("abort", issued);
            if (issued) n_reads++;
            i_Start = 1'b0;
            if (n_reads == 3 && !pulsed) begin
                drive_start(1, 1, 8'hAA);
                pulsed = 1;
            end
            if (n_reads == 5) RST = 1'b1;
            else begin
                @(posedge CLK); #1;
            end
        end
        check("abort/reads_before_rst", 64'(n_reads), 64'd5);
        check("abort/sb_left", 64'(sb_q.size()), 64'd3);
        @(posedge CLK); #1;
        RST = 1'b0;
        check("abort/en", 64'(o_Psram_En), 64'd0);
        check("abort/addr", 64'(o_Psram_Addr), 64'd0);
        check("abort/valid", 64'(o_Valid_WB_Psum), 64'd0);
        check("abort/busy", 64'(o_Busy), 64'd0);
        check("abort/done", 64'(o_Done), 64'd0);
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK); #1;
            check("abort/no_done", 64'(o_Done), 64'd0);
            check("abort/idle_en", 64'(o_Psram_En), 64'd0);
        end
        $display("abort: reads=%0d before reset, no done afterwards", n_reads);
        sb_q.delete();
    endtask

    initial begin
        vecs[0] = '{4,   2,   'h10, 0, 0, 8,   8};
        vecs[1] = '{4,   2,   'h10, 3, 3, 8,   11};
        vecs[2] = '{40,  1,   'h00, 0, 0, 32,  32};
        vecs[3] = '{1,   4,   'hFE, 0, 0, 4,   4};
        vecs[4] = '{0,   5,   'h00, 0, 0, 0,   0};
        vecs[5] = '{3,   0,   'h00, 0, 0, 0,   0};
        vecs[6] = '{1,   256, 'h37, 0, 0, 256, 256};
        vecs[7] = '{32,  2,   'hFF, 5, 1, 64,  65};
        vecs[8] = '{7,   3,   'h80, 0, 0, 21,  21};

        RST = 1'b1; i_Start = 1'b0; i_Num_Cols = '0; i_Num_Addr = '0;
        i_Base_Addr = '0; i_Stall = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset/en", 64'(o_Psram_En), 64'd0);
        check("reset/addr", 64'(o_Psram_Addr), 64'd0);
        check("reset/valid", 64'(o_Valid_WB_Psum), 64'd0);
        check("reset/busy", 64'(o_Busy), 64'd0);
        check("reset/done", 64'(o_Done), 64'd0);
        $display("reset: outputs idle");
        RST = 1'b0;

        for (int i = 0; i < 9; i++) run_case(vecs[i], i);
        run_abort();
        run_case(vecs[0], 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
